button_debounce: RTL and testbench
==================================

# button_debounce

Input-conditioning stage for the front-panel push button. It synchronises the raw, asynchronous, bouncing button into `clk`. It then qualifies each change with a stability counter, and drives a clean registered `level` into the pulse-rate generator that follows it. The gray counter stage consumes that generator's `pulse`. The block also emits single-cycle `rise`/`fall` strobes for control logic that needs edge events.

## Interface
- `STABLE_CYCLES`, default 2000000: number of consecutive synchronised samples that must agree before `level` changes. This is 20 ms at 100 MHz. Minimum legal value is 2.
- `CNT_W`, default 21: stability counter width. It must satisfy 2^CNT_W > STABLE_CYCLES-1.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_raw`  in  1  raw button pin. It is asynchronous to `clk` and bounces.
- `level`  out  1  debounced button state, registered and glitch-free.
- `rise`  out  1  one-cycle strobe, coincident with the cycle `level` becomes 1.
- `fall`  out  1  one-cycle strobe, coincident with the cycle `level` becomes 0.

## Operation
- Synchroniser: two flops, `s1 <= btn_raw` and `s2 <= s1`. Only `s2` feeds the rest of the logic. No other logic reads `btn_raw`.
- FSM has four states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
  - LOW: `level`=0. If `s2`=1, go to WAIT_HIGH and set `cnt`=0.
  - WAIT_HIGH: `level`=0.
    - If `s2`=0, go to LOW, clear `cnt`, emit no strobe.
    - If `s2`=1 and `cnt`==STABLE_CYCLES-1, go to HIGH, set `level`<=1 and `rise`<=1.
    - Otherwise `cnt`<=`cnt`+1.
  - HIGH: `level`=1. If `s2`=0, go to WAIT_LOW and set `cnt`=0.
  - WAIT_LOW: `level`=1.
    - If `s2`=1, go to HIGH, clear `cnt`, emit no strobe.
    - If `s2`=0 and `cnt`==STABLE_CYCLES-1, go to LOW, set `level`<=0 and `fall`<=1.
    - Otherwise `cnt`<=`cnt`+1.
- `rise` and `fall` are registered and deasserted on every cycle other than the transition cycle. They are never asserted together.
- `cnt` never exceeds STABLE_CYCLES-1. There is no wrap-around path.
- `level`, `rise` and `fall` are flop outputs with no combinational path from `btn_raw`. The downstream stage uses `level` as an asynchronous clear, so any glitch would reset it spuriously.

## Timing
- Reset values: `s1`=`s2`=0, state LOW, `cnt`=0, `level`=0, `rise`=0, `fall`=0.
- `rst` clears everything immediately, independent of `clk`. This applies mid-WAIT and mid-HIGH, and no `fall` strobe is emitted on reset.
- After reset release with the button held, the block re-qualifies the input. `level` rises with a `rise` strobe after the full latency below.
- Latency, with edge 0 as the first edge at which `btn_raw` is sampled at its new value:
  - edge 1: `s2` updates;
  - edge 2: FSM enters WAIT_x;
  - edge STABLE_CYCLES+2: `level` updates and the strobe asserts for exactly one cycle.
- Acceptance condition: `s2` must hold the new value on STABLE_CYCLES+1 consecutive edges, from edge 2 to edge STABLE_CYCLES+2.
- Any single-cycle reversal of `s2` during WAIT_x aborts qualification. The FSM returns to the previous stable state and the count restarts from 0 on the next change.
- Pulses shorter than 2 `clk` cycles may be missed entirely by the synchroniser. This is acceptable.
- Throughput: minimum spacing between a `rise` and the following `fall` is STABLE_CYCLES+1 cycles.

## Test plan
Bench overrides `STABLE_CYCLES`=4 and `CNT_W`=3.
- Clean press: `btn_raw` 0→1 sampled at edge 0 and held. Required: `level`=1 and `rise`=1 after edge 6, `rise`=0 after edge 7, `fall` never asserted.
- Bounce: `btn_raw` toggles 1,0,1,0 on successive edges, then holds 1. Required: no strobe during toggling, one `rise` exactly 6 edges after the last 0→1 sample, `level` stays 0 until then.
- Short glitch: in HIGH, `btn_raw`=0 for 3 cycles, then back to 1. Required: `level` stays 1 and `fall` never asserts.
- Release: in HIGH, `btn_raw` 1→0 and held. Required: `level`=0 and `fall`=1 for one cycle after edge 6, `rise` stays 0 throughout.
- Reset mid-operation: assert `rst` asynchronously while in WAIT_HIGH with `cnt`=2, with `btn_raw` held 1. Required:
  - all outputs 0 immediately;
  - after release, `rise` occurs 6 edges after the first post-reset sampling edge.
- Max-count check: drive `btn_raw`=1 for 1000 cycles. Required: exactly one `rise`, `cnt` never exceeds 3, and `level` remains 1 throughout.

Source files
------------

// File: rtl/button_debounce_if.sv
// Button conditioning bundle: raw pin in, debounced level and edge strobes out.
interface button_debounce_if;
  logic btn_raw;
  logic level;
  logic rise;
  logic fall;

  modport master (
    output btn_raw,
    input  level,
    input  rise,
    input  fall
  );

  modport slave (
    input  btn_raw,
    output level,
    output rise,
    output fall
  );
endinterface

// File: rtl/button_debounce.sv
// Front-panel button debouncer: two-flop synchroniser, then a stability-counted
// four-state FSM driving a registered level plus one-cycle rise/fall strobes.
module button_debounce #(
    parameter int unsigned STABLE_CYCLES = 2000000,
    parameter int unsigned CNT_W         = 21
) (
    input logic               clk,
    input logic               rst,
    button_debounce_if.slave  btn_if
);

    typedef enum logic [1:0] {
        StLow,
        StWaitHigh,
        StHigh,
        StWaitLow
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    // Only s2_q is consumed downstream; btn_raw never reaches any other logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_if.btn_raw;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLow;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                StLow: begin
                    if (s2_q) begin
                        state_q <= StWaitHigh;
                        cnt_q   <= '0;
                    end
                end
                StWaitHigh: begin
                    if (!s2_q) begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StHigh;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHigh: begin
                    if (!s2_q) begin
                        state_q <= StWaitLow;
                        cnt_q   <= '0;
                    end
                end
                StWaitLow: begin
                    if (s2_q) begin
                        state_q <= StHigh;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StLow;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from flops: downstream uses level as an async clear.
    assign btn_if.level = level_q;
    assign btn_if.rise  = rise_q;
    assign btn_if.fall  = fall_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: run-length reference model checked every cycle,
// plus directed press/bounce/glitch/release/reset/long-hold scenarios.
module tb_button_debounce;

    localparam int unsigned S = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    button_debounce_if bif ();

    button_debounce #(
        .STABLE_CYCLES(S),
        .CNT_W        (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_if(bif)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the value seen by the qualifier is the pin two edges earlier; level flips
    // once S+1 consecutive seen samples disagree with it.
    logic m_h1 = 1'b0, m_h2 = 1'b0, m_level = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    int   m_run = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_h1 <= 1'b0; m_h2 <= 1'b0; m_level <= 1'b0;
            m_rise <= 1'b0; m_fall <= 1'b0; m_run <= 0;
        end else begin
            m_h1   <= bif.btn_raw;
            m_h2   <= m_h1;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (m_h2 !== m_level) begin
                if (m_run == int'(S)) begin
                    m_level <= m_h2;
                    m_rise  <= m_h2;
                    m_fall  <= !m_h2;
                    m_run   <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    int rise_cnt = 0, fall_cnt = 0, cnt_over = 0;

    always @(negedge clk) begin
        check("model_level", bif.level, m_level);
        check("model_rise", bif.rise, m_rise);
        check("model_fall", bif.fall, m_fall);
        if (bif.rise) rise_cnt++;
        if (bif.fall) fall_cnt++;
        if (dut.cnt_q > 3'd3) cnt_over++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    int r0, f0, drops;

    initial begin
        bif.btn_raw = 1'b0;
        #1 rst = 1'b1;
        step(2);
        check("reset_level", bif.level, 0);
        check("reset_rise", bif.rise, 0);
        check("reset_fall", bif.fall, 0);
        check("reset_cnt", dut.cnt_q, 0);
        rst = 1'b0;
        step(3);

        // Clean press: sampled at edge 0, level/rise at edge 6.
        r0 = rise_cnt; f0 = fall_cnt;
        bif.btn_raw = 1'b1;
        step(6);
        check("press_level_e5", bif.level, 0);
        step(1);
        check("press_level_e6", bif.level, 1);
        check("press_rise_e6", bif.rise, 1);
        step(1);
        check("press_rise_e7", bif.rise, 0);
        check("press_level_e7", bif.level, 1);
        check("press_no_fall", fall_cnt - f0, 0);
        check("press_one_rise", rise_cnt - r0, 1);

        // Short glitch while high.
        f0 = fall_cnt;
        bif.btn_raw = 1'b0;
        step(3);
        bif.btn_raw = 1'b1;
        step(12);
        check("glitch_level", bif.level, 1);
        check("glitch_no_fall", fall_cnt - f0, 0);

        // Release.
        r0 = rise_cnt;
        bif.btn_raw = 1'b0;
        step(6);
        check("release_level_e5", bif.level, 1);
        step(1);
        check("release_level_e6", bif.level, 0);
        check("release_fall_e6", bif.fall, 1);
        step(1);
        check("release_fall_e7", bif.fall, 0);
        check("release_no_rise", rise_cnt - r0, 0);
        step(4);

        // Bounce 1,0,1,0 then hold 1; edge 0 is the final 0->1 sample.
        r0 = rise_cnt;
        bif.btn_raw = 1'b1; step(1);
        bif.btn_raw = 1'b0; step(1);
        bif.btn_raw = 1'b1; step(1);
        bif.btn_raw = 1'b0; step(1);
        bif.btn_raw = 1'b1;
        step(6);
        check("bounce_level_e5", bif.level, 0);
        check("bounce_no_early_rise", rise_cnt - r0, 0);
        step(1);
        check("bounce_rise_e6", bif.rise, 1);
        check("bounce_level_e6", bif.level, 1);
        step(3);

        // Async reset while high: level drops at once, no fall strobe.
        f0 = fall_cnt;
        #2 rst = 1'b1;
        #1;
        check("rst_high_level", bif.level, 0);
        check("rst_high_fall", bif.fall, 0);
        check("rst_high_rise", bif.rise, 0);
        step(1);
        rst = 1'b0;
        step(6);
        check("rst_high_requal_e5", bif.level, 0);
        step(1);
        check("rst_high_requal_rise", bif.rise, 1);
        check("rst_high_no_fall", fall_cnt - f0, 0);

        // Reset mid WAIT_HIGH with cnt=2.
        bif.btn_raw = 1'b0;
        step(8);
        check("prewait_level", bif.level, 0);
        bif.btn_raw = 1'b1;
        step(5);
        check("wait_cnt2", dut.cnt_q, 2);
        #2 rst = 1'b1;
        #1;
        check("rst_wait_level", bif.level, 0);
        check("rst_wait_rise", bif.rise, 0);
        check("rst_wait_cnt", dut.cnt_q, 0);
        step(1);
        rst = 1'b0;
        step(6);
        check("rst_wait_requal_e5", bif.level, 0);
        step(1);
        check("rst_wait_requal_rise", bif.rise, 1);

        // Long hold: exactly one rise, counter bounded, level stays high.
        bif.btn_raw = 1'b0;
        step(8);
        r0 = rise_cnt; cnt_over = 0; drops = 0;
        bif.btn_raw = 1'b1;
        step(7);
        for (int i = 0; i < 993; i++) begin
            step(1);
            if (!bif.level) drops++;
        end
        check("hold_one_rise", rise_cnt - r0, 1);
        check("hold_cnt_bound", cnt_over, 0);
        check("hold_level_drops", drops, 0);
        check("hold_level_end", bif.level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
